// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Issue-side handshake bundle for the multi-cycle RV32M
//                divider: start pulse with operation, operands and rd on one
//                side; busy, completion pulse and writeback on the other.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [4:0]      rd_in;
  logic            busy;
  logic            div_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            reg_we_out;

  // Issue logic (decode stage) side
  modport master (
    output start, div_op, dividend, divisor, rd_in,
    input  busy, div_ready, result, rd_out, reg_we_out
  );

  // Divider side
  modport slave (
    input  start, div_op, dividend, divisor, rd_in,
    output busy, div_ready, result, rd_out, reg_we_out
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Restoring
//                shift-subtract on operand magnitudes, one quotient bit per
//                cycle, followed by a sign-fix cycle and a one-cycle
//                completion pulse. Divide-by-zero, signed overflow and
//                unknown opcodes complete in the cycle after the start.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 32
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  div_unit_if.slave   bus
);

  localparam int         c_CNT_W   = $clog2(XLEN + 1);
  localparam logic [3:0] c_OP_DIV  = 4'd1;
  localparam logic [3:0] c_OP_DIVU = 4'd2;
  localparam logic [3:0] c_OP_REM  = 4'd3;
  localparam logic [3:0] c_OP_REMU = 4'd4;
  localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_busy;
  logic                w_ready;

  logic [3:0]          r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [XLEN:0]       r_rem;     // partial remainder, one guard bit
  logic [XLEN-1:0]     r_quo;     // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]     r_dvs;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd;

  // ---- decode of the operation presented with start ----
  logic                w_accept;
  logic                w_signed_op;
  logic                w_valid_op;
  logic                w_is_div;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_result;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;

  assign w_accept    = (r_state == S_IDLE) && bus.start && (bus.div_op != 4'd0);
  assign w_signed_op = (bus.div_op == c_OP_DIV) || (bus.div_op == c_OP_REM);
  assign w_valid_op  = (bus.div_op >= c_OP_DIV) && (bus.div_op <= c_OP_REMU);
  assign w_is_div    = (bus.div_op == c_OP_DIV) || (bus.div_op == c_OP_DIVU);
  assign w_a_neg     = bus.dividend[XLEN-1];
  assign w_b_neg     = bus.divisor[XLEN-1];
  assign w_div_zero  = (bus.divisor == '0);
  assign w_ovf       = w_signed_op && (bus.dividend == c_INT_MIN) && (bus.divisor == '1);
  assign w_special   = !w_valid_op || w_div_zero || w_ovf;

  // Magnitudes; -2^(XLEN-1) negates to itself, which is the correct unsigned magnitude.
  assign w_a_mag = (w_signed_op && w_a_neg) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_b_mag = (w_signed_op && w_b_neg) ? (~bus.divisor  + 1'b1) : bus.divisor;

  // Results that bypass the iteration: x/0, signed overflow, unknown opcode.
  always_comb begin
    w_special_result = '0;
    if (!w_valid_op) begin
      w_special_result = '0;
    end else if (w_div_zero) begin
      w_special_result = w_is_div ? '1 : bus.dividend;
    end else if (w_ovf) begin
      w_special_result = w_is_div ? c_INT_MIN : '0;
    end
  end

  // ---- one restoring step ----
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN:0]   w_rem_next;
  logic [XLEN-1:0] w_quo_next;

  assign w_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  // Keep the difference when it did not borrow, otherwise restore.
  always_comb begin
    w_rem_next = w_shift;
    w_quo_next = {r_quo[XLEN-2:0], 1'b0};
    if (!w_diff[XLEN]) begin
      w_rem_next = w_diff;
      w_quo_next = {r_quo[XLEN-2:0], 1'b1};
    end
  end

  // ---- sign correction ----
  logic [XLEN-1:0] w_quo_final;
  logic [XLEN-1:0] w_rem_final;
  logic [XLEN-1:0] w_fix_result;

  assign w_quo_final  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_final  = r_neg_r ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];
  assign w_fix_result = ((r_op == c_OP_DIV) || (r_op == c_OP_DIVU)) ? w_quo_final : w_rem_final;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_accept) begin
          w_next_state = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == c_CNT_W'(1)) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_ready      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.div_op;
            r_rd    <= bus.rd_in;
            r_neg_q <= w_signed_op && (w_a_neg ^ w_b_neg);
            r_neg_r <= w_signed_op && w_a_neg;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_cnt   <= c_CNT_W'(XLEN);
            if (w_special) begin
              r_result <= w_special_result;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= w_fix_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = w_busy;
  assign bus.div_ready  = w_ready;
  assign bus.result     = r_result;
  assign bus.rd_out     = r_rd;
  assign bus.reg_we_out = w_ready && (r_rd != 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit: directed cases, handshake
//                corner cases, reset mid-operation and randomized operations
//                against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

  localparam int          XLEN      = 32;
  localparam logic [31:0] c_INT_MIN = 32'h8000_0000;

  logic clk;
  logic reset_n;
  int   n_asserts = 0;
  int   n_fail    = 0;

  div_unit_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain RV32M arithmetic including its special cases.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      4'd1: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == c_INT_MIN && b == 32'hFFFF_FFFF) r = c_INT_MIN;
            else r = $unsigned($signed(a) / $signed(b));
      4'd2: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd3: if (b == 0) r = a;
            else if (a == c_INT_MIN && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = $unsigned($signed(a) % $signed(b));
      4'd4: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 4'd1 || op > 4'd4) return 1;
    if (b == 0) return 1;
    if ((op == 4'd1 || op == 4'd3) && a == c_INT_MIN && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is at a falling edge with the divider idle. Start is driven for
  // this one cycle; inputs are scrambled afterwards, and an optional second
  // start is pulsed at cycle `ghost` while the operation is in flight.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int ghost,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    lat = -1;
    bus.start    = 1'b1;
    bus.div_op   = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.rd_in    = rd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start    = (c == ghost);
      bus.div_op   = 4'($urandom_range(1, 4));
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      bus.rd_in    = 5'($urandom);
      if (c == 1) check({tag, " busy"}, 32'(bus.busy), 32'd1);
      if (bus.div_ready) begin
        lat = c;
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
    check({tag, " reg_we"}, 32'(bus.reg_we_out), 32'(rd != 5'd0));
    @(negedge clk);
    check({tag, " pulse end"}, {30'd0, bus.busy, bus.div_ready}, 32'd0);
  endtask

  task automatic run_ref(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    run_op(tag, op, a, b, rd, -1, ref_result(op, a, b), ref_latency(op, a, b));
  endtask

  initial begin
    int seen;
    logic [3:0]  op;
    logic [31:0] a, b;

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.div_op   = 4'd0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    bus.rd_in    = 5'd0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset ready", 32'(bus.div_ready), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    check("reset we", 32'(bus.reg_we_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases with hand-derived answers.
    run_op("divu 100/7", 4'd2, 32'd100, 32'd7, 5'd5, -1, 32'd14, 34);
    run_op("div -7/2",   4'd1, 32'hFFFF_FFF9, 32'd2, 5'd1, -1, 32'hFFFF_FFFD, 34);
    run_op("rem -7/2",   4'd3, 32'hFFFF_FFF9, 32'd2, 5'd2, -1, 32'hFFFF_FFFF, 34);
    run_op("remu",       4'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, -1, 32'd1, 34);
    run_op("rem 7/-2",   4'd3, 32'd7, 32'hFFFF_FFFE, 5'd4, -1, 32'd1, 34);
    run_op("divu 5/0",   4'd2, 32'd5, 32'd0, 5'd6, -1, 32'hFFFF_FFFF, 1);
    run_op("rem 5/0",    4'd3, 32'd5, 32'd0, 5'd7, -1, 32'd5, 1);
    run_op("div ovf",    4'd1, c_INT_MIN, 32'hFFFF_FFFF, 5'd8, -1, c_INT_MIN, 1);
    run_op("rem ovf",    4'd3, c_INT_MIN, 32'hFFFF_FFFF, 5'd8, -1, 32'd0, 1);
    run_op("bad op",     4'd7, 32'd50, 32'd5, 5'd9, -1, 32'd0, 1);
    run_op("rd0 div",    4'd1, 32'd9, 32'd3, 5'd0, -1, 32'd3, 34);
    run_op("div min/3",  4'd1, c_INT_MIN, 32'd3, 5'd10, -1, 32'hD555_5556, 34);

    // Second start while busy is ignored; next start lands with no dead cycle.
    run_op("ghost",      4'd2, 32'd100, 32'd7, 5'd5, 10, 32'd14, 34);
    run_op("b2b",        4'd4, 32'd100, 32'd7, 5'd11, -1, 32'd2, 34);

    // A start carrying the NOP opcode is not accepted.
    bus.start  = 1'b1;
    bus.div_op = 4'd0;
    bus.rd_in  = 5'd3;
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy || bus.div_ready) seen++;
    end
    check("nop ignored", 32'(seen), 32'd0);

    // Reset in the middle of a division discards it.
    bus.start    = 1'b1;
    bus.div_op   = 4'd2;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    bus.rd_in    = 5'd9;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst ready", 32'(bus.div_ready), 32'd0);
    check("midrst result", bus.result, 32'd0);
    check("midrst rd_out", 32'(bus.rd_out), 32'd0);
    check("midrst we", 32'(bus.reg_we_out), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.div_ready || bus.busy) seen++;
    end
    check("midrst no pulse", 32'(seen), 32'd0);
    run_op("post rst",   4'd2, 32'd1000, 32'd3, 5'd9, -1, 32'd333, 34);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 4));
      a  = ($urandom_range(0, 7) == 0) ? c_INT_MIN : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_ref("rand", op, a, b, 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
